// File: rtl/switch_poll_logger.sv
// Polls a switch PIO at a fixed rate, debounces the samples, and logs each
// accepted change as a timestamped record into a circular RAM region.
module switch_poll_logger #(
  parameter int WIDTH        = 4,
  parameter int POLL_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int LOG_DEPTH    = 256,
  parameter int LOG_BASE     = 0,
  parameter int RAM_ADDR_W   = 10
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  output logic [1:0]                   pio_address,
  input  logic [31:0]                  pio_readdata,
  output logic [RAM_ADDR_W-1:0]        ram_address,
  output logic                         ram_write,
  output logic [31:0]                  ram_writedata,
  output logic [3:0]                   ram_byteenable,
  input  logic                         ram_waitrequest,
  input  logic [$clog2(LOG_DEPTH)-1:0] rd_ptr,
  output logic [$clog2(LOG_DEPTH)-1:0] wr_ptr,
  output logic [WIDTH-1:0]             stable_state,
  output logic                         overflow,
  input  logic                         clear_overflow,
  output logic                         irq
);

  localparam int PW = $clog2(LOG_DEPTH);
  localparam int TW = $clog2(POLL_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t           state_r, state_nxt_s;
  logic [TW-1:0]    tick_cnt_r;
  logic             tick_s;
  logic [15:0]      ts_r;
  logic             init_r;
  logic [WIDTH-1:0] cand_r, cand_nxt_s;
  logic [DW-1:0]    deb_cnt_r, deb_cnt_nxt_s;
  logic [WIDTH-1:0] sample_s;
  logic             accept_s, full_s, load_s, done_s, drop_s;
  logic             unused_s;

  assign pio_address    = 2'b00;
  assign ram_byteenable = 4'hF;
  assign sample_s       = pio_readdata[WIDTH-1:0];
  assign unused_s       = ^pio_readdata[31:WIDTH];
  assign tick_s         = enable && (tick_cnt_r == TW'(POLL_DIV - 1));
  assign full_s         = (wr_ptr + PW'(1)) == rd_ptr;
  assign ram_write      = (state_r == WRITE);

  // Poll-rate divider and free-running tick timestamp
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_r <= '0;
      ts_r       <= 16'd0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
      ts_r       <= ts_r + 16'd1;
    end else if (enable) begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // Debounce decision for the current tick
  always_comb begin
    accept_s      = 1'b0;
    cand_nxt_s    = cand_r;
    deb_cnt_nxt_s = deb_cnt_r;
    if (tick_s && init_r) begin
      if (sample_s == stable_state) begin
        deb_cnt_nxt_s = '0;
      end else if (sample_s == cand_r) begin
        if (int'(deb_cnt_r) + 1 == DEBOUNCE_CNT) begin
          accept_s      = 1'b1;
          deb_cnt_nxt_s = '0;
        end else begin
          deb_cnt_nxt_s = deb_cnt_r + DW'(1);
        end
      end else begin
        cand_nxt_s = sample_s;
        if (DEBOUNCE_CNT == 1) begin
          accept_s      = 1'b1;
          deb_cnt_nxt_s = '0;
        end else begin
          deb_cnt_nxt_s = DW'(1);
        end
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // Debounce state; the first tick after reset only seeds stable_state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_r       <= 1'b0;
      cand_r       <= '0;
      deb_cnt_r    <= '0;
      stable_state <= '0;
    end else begin
      cand_r    <= cand_nxt_s;
      deb_cnt_r <= deb_cnt_nxt_s;
      if (tick_s && !init_r) begin
        stable_state <= sample_s;
        init_r       <= 1'b1;
      end else if (accept_s) begin
        stable_state <= sample_s;
      end
    end
  end

  // Write FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_nxt_s;
  end

  // Write FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (accept_s && !full_s) state_nxt_s = WRITE; else state_nxt_s = IDLE;
      WRITE:   if (!ram_waitrequest)    state_nxt_s = IDLE;  else state_nxt_s = WRITE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Write FSM control decode: an event arriving while busy or full is lost
  always_comb begin
    load_s = 1'b0;
    done_s = 1'b0;
    drop_s = 1'b0;
    case (state_r)
      IDLE: begin
        load_s = accept_s && !full_s;
        drop_s = accept_s && full_s;
      end
      WRITE: begin
        done_s = !ram_waitrequest;
        drop_s = accept_s;
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Write datapath, pointer, sticky overflow and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_address   <= RAM_ADDR_W'(LOG_BASE);
      ram_writedata <= 32'd0;
      wr_ptr        <= '0;
      overflow      <= 1'b0;
      irq           <= 1'b0;
    end else begin
      if (load_s) begin
        ram_address   <= RAM_ADDR_W'(LOG_BASE) + RAM_ADDR_W'(wr_ptr);
        ram_writedata <= {ts_r, 8'(stable_state), 8'(sample_s)};
      end
      if (done_s) wr_ptr <= wr_ptr + PW'(1);
      if (drop_s)              overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
      irq <= (wr_ptr != rd_ptr);
    end
  end

endmodule

// File: tb/tb_switch_poll_logger.sv
// Directed bench for switch_poll_logger with a 4-cycle poll, 3-sample debounce
// and a 4-entry log so that full and wrap cases are quick to reach.
module tb_switch_poll_logger;

  localparam int BASE = 16;

  logic        clk = 1'b0;
  logic        reset_n, enable, ram_waitrequest, clear_overflow;
  logic [31:0] pio_readdata;
  logic [1:0]  rd_ptr, wr_ptr, pio_address;
  logic [9:0]  ram_address;
  logic        ram_write, overflow, irq;
  logic [31:0] ram_writedata;
  logic [3:0]  ram_byteenable, stable_state;

  int          n_checks = 0, n_fail = 0, n_writes = 0, n_tick = 0;
  logic [15:0] ts_exp;

  always #5 clk = ~clk;

  switch_poll_logger #(.WIDTH(4), .POLL_DIV(4), .DEBOUNCE_CNT(3), .LOG_DEPTH(4),
                       .LOG_BASE(BASE), .RAM_ADDR_W(10)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pio_address(pio_address),
    .pio_readdata(pio_readdata), .ram_address(ram_address), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_byteenable(ram_byteenable),
    .ram_waitrequest(ram_waitrequest), .rd_ptr(rd_ptr), .wr_ptr(wr_ptr),
    .stable_state(stable_state), .overflow(overflow), .clear_overflow(clear_overflow),
    .irq(irq)
  );

  // Count completed RAM writes
  always @(posedge clk) begin
    if (reset_n && ram_write && !ram_waitrequest) n_writes <= n_writes + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Release reset so that each later 4-cycle group has its tick on the 2nd edge
  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tick = 0;
  endtask

  task automatic group();
    repeat (4) @(posedge clk);
    #1;
    n_tick++;
  endtask

  task automatic hold(input logic [3:0] sw, input int n);
    pio_readdata = {28'd0, sw};
    for (int i = 0; i < n; i++) group();
  endtask

  task automatic clear_group();
    clear_overflow = 1'b1;
    @(posedge clk);
    #1;
    clear_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tick++;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; ram_waitrequest = 1'b0; clear_overflow = 1'b0;
    rd_ptr = 2'd0; pio_readdata = 32'd0;
    #12;
    check_eq("const_pio_address", {30'd0, pio_address}, 32'd0);
    check_eq("const_byteenable", {28'd0, ram_byteenable}, 32'hF);
    release_reset();

    // first tick only seeds stable_state
    group();
    check_eq("init_stable", {28'd0, stable_state}, 32'd0);
    check_eq("init_no_write", n_writes, 32'd0);

    // glitch 0->5 for two ticks then back: nothing logged
    hold(4'd5, 2);
    hold(4'd0, 1);
    check_eq("glitch_no_write", n_writes, 32'd0);
    check_eq("glitch_stable", {28'd0, stable_state}, 32'd0);
    ts_exp = 16'(n_tick + 2);
    hold(4'd5, 3);
    check_eq("ev1_writes", n_writes, 32'd1);
    check_eq("ev1_addr", {22'd0, ram_address}, BASE);
    check_eq("ev1_data", ram_writedata, {ts_exp, 8'h00, 8'h05});
    check_eq("ev1_wr_ptr", {30'd0, wr_ptr}, 32'd1);
    check_eq("ev1_irq", {31'd0, irq}, 32'd1);
    check_eq("ev1_stable", {28'd0, stable_state}, 32'd5);

    // waitrequest stall: request held stable for six cycles
    ram_waitrequest = 1'b1;
    hold(4'd6, 2);
    ts_exp = 16'(n_tick);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      check_eq("stall_write", {31'd0, ram_write}, 32'd1);
      check_eq("stall_addr", {22'd0, ram_address}, BASE + 1);
      check_eq("stall_data", ram_writedata, {ts_exp, 8'h05, 8'h06});
      if (i < 5) begin
        @(posedge clk);
        #1;
      end
    end
    check_eq("stall_no_early_write", n_writes, 32'd1);
    ram_waitrequest = 1'b0;
    @(posedge clk);
    #1;
    n_tick += 2;
    check_eq("stall_write_low", {31'd0, ram_write}, 32'd0);
    check_eq("stall_wr_ptr", {30'd0, wr_ptr}, 32'd2);
    check_eq("stall_writes", n_writes, 32'd2);

    // collision: a change accepted while the previous write is stalled
    ram_waitrequest = 1'b1;
    ts_exp = 16'(n_tick + 2);
    hold(4'd7, 3);
    check_eq("col_pending", {31'd0, ram_write}, 32'd1);
    check_eq("col_addr", {22'd0, ram_address}, BASE + 2);
    hold(4'd8, 3);
    check_eq("col_overflow", {31'd0, overflow}, 32'd1);
    check_eq("col_stable", {28'd0, stable_state}, 32'd8);
    check_eq("col_data_kept", ram_writedata, {ts_exp, 8'h06, 8'h07});
    ram_waitrequest = 1'b0;
    group();
    check_eq("col_writes", n_writes, 32'd3);
    check_eq("col_wr_ptr", {30'd0, wr_ptr}, 32'd3);
    clear_group();
    check_eq("clear_overflow1", {31'd0, overflow}, 32'd0);

    // log full with rd_ptr=0, wr_ptr=3: change dropped
    hold(4'd9, 3);
    check_eq("full_overflow", {31'd0, overflow}, 32'd1);
    check_eq("full_stable", {28'd0, stable_state}, 32'd9);
    check_eq("full_no_write", n_writes, 32'd3);
    check_eq("full_wr_ptr", {30'd0, wr_ptr}, 32'd3);
    clear_group();
    check_eq("clear_overflow2", {31'd0, overflow}, 32'd0);

    // wrap from the last slot back to 0
    rd_ptr = 2'd2;
    ts_exp = 16'(n_tick + 2);
    hold(4'd10, 3);
    check_eq("wrap_addr", {22'd0, ram_address}, BASE + 3);
    check_eq("wrap_data", ram_writedata, {ts_exp, 8'h09, 8'h0A});
    check_eq("wrap_wr_ptr", {30'd0, wr_ptr}, 32'd0);
    check_eq("wrap_irq", {31'd0, irq}, 32'd1);
    check_eq("wrap_writes", n_writes, 32'd4);
    rd_ptr = 2'd0;
    @(posedge clk);
    #1;
    check_eq("drain_irq", {31'd0, irq}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    n_tick++;

    // reset in the middle of a stalled write
    ram_waitrequest = 1'b1;
    hold(4'd11, 3);
    check_eq("rst_pre_write", {31'd0, ram_write}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("rst_write", {31'd0, ram_write}, 32'd0);
    check_eq("rst_addr", {22'd0, ram_address}, BASE);
    check_eq("rst_data", ram_writedata, 32'd0);
    check_eq("rst_wr_ptr", {30'd0, wr_ptr}, 32'd0);
    check_eq("rst_stable", {28'd0, stable_state}, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    ram_waitrequest = 1'b0;
    pio_readdata = 32'd12;
    release_reset();
    group();
    check_eq("post_rst_stable", {28'd0, stable_state}, 32'd12);
    check_eq("post_rst_no_write", n_writes, 32'd4);
    check_eq("post_rst_write_low", {31'd0, ram_write}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
